sr_ff_bank: RTL and testbench
=============================

Name: sr_ff_bank

Overview:
Parametrised, clocked successor to the team's single gate-level SR cell. It holds WIDTH independent SR storage bits with a selectable conflict-resolution mode (reset-dominant, set-dominant, JK-toggle, hold). It also provides an optional input synchroniser, optional rising-edge event detection, and per-channel conflict reporting with sticky error flags. It sits between asynchronous or bouncy control inputs (switches, external strobes) and synchronous datapath logic that needs latched status bits.

Parameters:
WIDTH, 8, number of independent SR channels (1..32).
MODE, 0, conflict rule when set and reset are both active: 0=reset-dominant, 1=set-dominant, 2=toggle (JK), 3=hold. Any other value must fail elaboration.
SYNC_STAGES, 2, flops per input bit before use (0..3). 0 means inputs are used directly.
EDGE_MODE, 0, 0 = inputs are level-sensitive; 1 = only rising edges of the synchronised inputs act.
RESET_VAL, 0, WIDTH-bit value loaded into q by rst_n and by clr.

Ports:
clk  in  1  sole clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
s  in  WIDTH  per-channel set request.
r  in  WIDTH  per-channel reset request.
en  in  1  update enable. When low, q holds and no conflicts are flagged.
clr  in  1  synchronous clear of q to RESET_VAL.
err_clr  in  1  synchronous clear of err_sticky.
q  out  WIDTH  stored state.
q_n  out  WIDTH  always exactly ~q. No both-low state exists.
conflict  out  WIDTH  registered one-cycle pulse per channel on a set/reset collision.
err_sticky  out  WIDTH  per channel, sets on any collision and holds until err_clr.
any_err  out  1  OR-reduction of err_sticky (combinational from registers).

Behaviour:
- Reset is asynchronous and active-low; clk is the single clock. While rst_n=0: q=RESET_VAL, q_n=~RESET_VAL, conflict=0, err_sticky=0, any_err=0, all synchroniser and edge-history flops=0.
- Input conditioning, applied to each bit of s and r independently:
  - s_sy/r_sy are the inputs delayed through SYNC_STAGES flops.
  - EDGE_MODE=0: s_ev=s_sy, r_ev=r_sy.
  - EDGE_MODE=1: s_ev = s_sy & ~s_prev, where s_prev is s_sy registered one cycle; r_ev is formed the same way.
- Latency: an input change is visible on q after SYNC_STAGES+1 rising edges (edge-detect adds no cycle).
- q update per channel i at each rising clk edge, in priority order:
  1. clr=1: q=RESET_VAL. This overrides en, s and r.
  2. en=0: hold.
  3. s_ev=1, r_ev=0: q=1.
  4. s_ev=0, r_ev=1: q=0.
  5. Both 0: hold.
  6. Both 1: MODE 0 gives q=0; MODE 1 gives q=1; MODE 2 gives q=~q; MODE 3 holds.
- Collision is defined as s_ev[i]&r_ev[i]&en&~clr.
  - conflict[i] is registered: high exactly the cycle after a collision, low otherwise. It pulses every cycle a level collision persists.
  - err_sticky[i] sets on a collision. err_clr clears all bits. If a collision and err_clr occur in the same cycle, the set wins for that bit.
- Edge mode after reset: s_prev=0, so an input held high through reset release produces exactly one event, SYNC_STAGES cycles after release.
- Reset asserted mid-operation: all state clears immediately, with no clock required. Pending synchroniser contents are discarded.
- Channels are fully independent; no cross-channel interaction except any_err.

Decomposition:
- Package sr_bank_pkg holds the mode constants MODE_RDOM=0, MODE_SDOM=1, MODE_TOGGLE=2, MODE_HOLD=3, plus a max-WIDTH constant of 32.
- One natural sub-module, sr_in_cond: a WIDTH-wide synchroniser plus optional edge detector, parametrised by SYNC_STAGES and EDGE_MODE. It is instantiated twice, once for s and once for r.
- Mode resolution, sticky flags and q registers stay in the top module.

Test Plan:
- Reset and basic set/reset. Config: WIDTH=4, MODE=0, SYNC_STAGES=2, EDGE_MODE=0, RESET_VAL=4'b1010. Stimulus: hold rst_n=0, then release. Expect q=1010, q_n=0101. Then pulse s=0001 for one cycle: q becomes 1011 exactly 3 edges later. Then r=1000 gives q=0011.
- Mode collisions. Stimulus: s=r=0001 held 4 cycles, en=1. Expected q[0] per MODE:
  - MODE 0: q[0]=0.
  - MODE 1: q[0]=1.
  - MODE 2: q[0] toggles every cycle (4 toggles return it to its start value).
  - MODE 3: q[0] unchanged.
  - All modes: conflict[0] high for 4 consecutive cycles, err_sticky[0]=1, any_err=1.
- Edge mode. Config: EDGE_MODE=1, SYNC_STAGES=0, MODE=2. Stimulus: s=r=0010 held high 5 cycles. Expect q[1] toggles once only and conflict[1] pulses once. Also: s held high through reset release gives one set event.
- clr and en priority. Stimulus: q=1111, then clr=1 with s=1111 gives q=RESET_VAL. Then en=0 with s=0101, r=1010 gives q unchanged and conflict=0.
- Sticky clear race. Stimulus: err_clr=1 in the same cycle as a channel-2 collision. Expect err_sticky[2]=1 and all other bits cleared. Next cycle with err_clr=1 and no collision gives err_sticky=0000 and any_err=0.
- Async reset mid-operation. Stimulus: drop rst_n between clock edges while q=0110 and err_sticky=0001. Expect immediate q=RESET_VAL and err_sticky=0, with no clk edge needed.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared constants and the collision-resolution rule for the SR storage bank.
package sr_bank_pkg;

    localparam int MODE_RDOM   = 0;
    localparam int MODE_SDOM   = 1;
    localparam int MODE_TOGGLE = 2;
    localparam int MODE_HOLD   = 3;
    localparam int MAX_WIDTH   = 32;

    // Next value of one bit when set and reset are both active.
    function automatic logic resolve_both(input int mode, input logic cur);
        case (mode)
            MODE_RDOM:   return 1'b0;
            MODE_SDOM:   return 1'b1;
            MODE_TOGGLE: return ~cur;
            default:     return cur;
        endcase
    endfunction

endpackage

// File: rtl/sr_in_cond.sv
// Per-bit input conditioning: optional synchroniser chain followed by an
// optional rising-edge detector that adds no extra cycle of latency.
module sr_in_cond #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] ev
);

    logic [WIDTH-1:0] sy;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sy = d;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            logic [WIDTH-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = d;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_d[k];
                    end
                end
            end

            assign sy = sync_q[SYNC_STAGES-1];
        end

        if (EDGE_MODE != 0) begin : g_edge
            logic [WIDTH-1:0] prev_q;
            logic [WIDTH-1:0] prev_d;

            always_comb prev_d = sy;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= '0;
                end else begin
                    prev_q <= prev_d;
                end
            end

            // Reset history of 0 means a level held through reset release fires once.
            assign ev = sy & ~prev_q;
        end else begin : g_level
            assign ev = sy;
        end
    endgenerate

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent clocked SR bits with selectable collision rule,
// input conditioning, per-channel conflict pulses and sticky error flags.
module sr_ff_bank
    import sr_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               MODE        = 0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_MODE   = 0,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             en,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] conflict,
    output logic [WIDTH-1:0] err_sticky,
    output logic             any_err
);

    generate
        if (MODE < MODE_RDOM || MODE > MODE_HOLD) begin : g_bad_mode
            $error("sr_ff_bank: MODE must be 0..3");
        end
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("sr_ff_bank: WIDTH must be 1..32");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("sr_ff_bank: SYNC_STAGES must be 0..3");
        end
        if (EDGE_MODE < 0 || EDGE_MODE > 1) begin : g_bad_edge
            $error("sr_ff_bank: EDGE_MODE must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] s_ev;
    logic [WIDTH-1:0] r_ev;
    logic [WIDTH-1:0] collision;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] conflict_q, conflict_d;
    logic [WIDTH-1:0] err_sticky_q, err_sticky_d;

    sr_in_cond #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_MODE  (EDGE_MODE)
    ) u_s_cond (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (s),
        .ev   (s_ev)
    );

    sr_in_cond #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_MODE  (EDGE_MODE)
    ) u_r_cond (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (r),
        .ev   (r_ev)
    );

    always_comb begin
        collision = s_ev & r_ev & {WIDTH{en & ~clr}};
        q_d       = q_q;
        if (clr) begin
            q_d = RESET_VAL;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({s_ev[i], r_ev[i]})
                    2'b10:   q_d[i] = 1'b1;
                    2'b01:   q_d[i] = 1'b0;
                    2'b11:   q_d[i] = resolve_both(MODE, q_q[i]);
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
        conflict_d   = collision;
        // A collision in the same cycle as err_clr keeps its bit set.
        err_sticky_d = (err_clr ? '0 : err_sticky_q) | collision;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q          <= RESET_VAL;
            conflict_q   <= '0;
            err_sticky_q <= '0;
        end else begin
            q_q          <= q_d;
            conflict_q   <= conflict_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign q          = q_q;
    assign q_n        = ~q_q;
    assign conflict   = conflict_q;
    assign err_sticky = err_sticky_q;
    assign any_err    = |err_sticky_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench: four level-mode banks (MODE 0..3) and one edge-mode
// toggle bank share stimulus and are checked against a log-based model.
module tb_sr_ff_bank;

    localparam int         ND = 5;
    localparam logic [3:0] RV = 4'b1010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] s = '0, r = '0;
    logic       en = 1'b1, clr = 1'b0, err_clr = 1'b0;

    logic [3:0] q_o [ND];
    logic [3:0] qn_o [ND];
    logic [3:0] conf_o [ND];
    logic [3:0] err_o [ND];
    logic       anyerr_o [ND];

    int vecs  = 0;
    int fails = 0;

    // Model state and the log of inputs applied at each edge since reset.
    logic [3:0] mq [ND];
    logic [3:0] mconf [ND];
    logic [3:0] merr [ND];
    logic [3:0] s_log [$];
    logic [3:0] r_log [$];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lvl
            sr_ff_bank #(
                .WIDTH(4), .MODE(gi), .SYNC_STAGES(2), .EDGE_MODE(0), .RESET_VAL(RV)
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .clr(clr),
                .err_clr(err_clr), .q(q_o[gi]), .q_n(qn_o[gi]), .conflict(conf_o[gi]),
                .err_sticky(err_o[gi]), .any_err(anyerr_o[gi])
            );
        end
    endgenerate

    sr_ff_bank #(
        .WIDTH(4), .MODE(2), .SYNC_STAGES(0), .EDGE_MODE(1), .RESET_VAL(RV)
    ) u_edge (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .clr(clr),
        .err_clr(err_clr), .q(q_o[4]), .q_n(qn_o[4]), .conflict(conf_o[4]),
        .err_sticky(err_o[4]), .any_err(anyerr_o[4])
    );

    function automatic int dut_mode(input int m);
        return (m < 4) ? m : 2;
    endfunction

    function automatic int dut_sync(input int m);
        return (m < 4) ? 2 : 0;
    endfunction

    function automatic logic [3:0] log_at(input bit is_s, input int k);
        if (k < 0) return 4'b0;
        return is_s ? s_log[k] : r_log[k];
    endfunction

    // Event seen by bank m at the newest logged edge.
    function automatic logic [3:0] ev_of(input bit is_s, input int m);
        int         k;
        logic [3:0] cur;
        k   = s_log.size() - 1 - dut_sync(m);
        cur = log_at(is_s, k);
        if (m == 4) cur = cur & ~log_at(is_s, k - 1);
        return cur;
    endfunction

    function automatic string got_str(input int m);
        return $sformatf("q=%b q_n=%b conflict=%b err=%b any=%b",
                         q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]);
    endfunction

    function automatic string want_str(input int m);
        return $sformatf("q=%b q_n=%b conflict=%b err=%b any=%b",
                         mq[m], ~mq[m], mconf[m], merr[m], |merr[m]);
    endfunction

    task automatic model_reset();
        s_log.delete();
        r_log.delete();
        for (int m = 0; m < ND; m++) begin
            mq[m] = RV; mconf[m] = '0; merr[m] = '0;
        end
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUTs.
    task automatic step();
        logic [3:0] sev, rev, coll, nq;
        s_log.push_back(s);
        r_log.push_back(r);
        for (int m = 0; m < ND; m++) begin
            sev  = ev_of(1'b1, m);
            rev  = ev_of(1'b0, m);
            coll = sev & rev & {4{en & ~clr}};
            nq   = mq[m];
            if (clr) nq = RV;
            else if (en) begin
                for (int b = 0; b < 4; b++) begin
                    if (sev[b] && !rev[b]) nq[b] = 1'b1;
                    else if (rev[b] && !sev[b]) nq[b] = 1'b0;
                    else if (sev[b] && rev[b]) begin
                        case (dut_mode(m))
                            0: nq[b] = 1'b0;
                            1: nq[b] = 1'b1;
                            2: nq[b] = ~mq[m][b];
                            default: nq[b] = mq[m][b];
                        endcase
                    end
                end
            end
            mconf[m] = coll;
            merr[m]  = (err_clr ? 4'b0 : merr[m]) | coll;
            mq[m]    = nq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        s = '0; r = '0; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < ND; m++) begin
            vecs++;
            if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {RV, ~RV, 8'h00, 1'b0}) begin
                fails++;
                $display("FAIL reset dut%0d: got %s, want q=%b q_n=%b conflict=0000 err=0000 any=0",
                         m, got_str(m), RV, ~RV);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_set_reset();
        logic [3:0] st [7] = '{4'h1, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
        logic [3:0] rt [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
        for (int c = 0; c < 7; c++) begin
            s = st[c]; r = rt[c];
            step();
            for (int m = 0; m < ND; m++) begin
                vecs++;
                if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {mq[m], ~mq[m], mconf[m], merr[m], |merr[m]}) begin
                    fails++;
                    $display("FAIL set_reset c%0d dut%0d: got %s, want %s", c, m, got_str(m), want_str(m));
                end
            end
            // s pulse applied before edge 0 lands on edge 2; r before edge 4 lands on edge 6
            if (c == 1 || c == 2 || c == 6) begin
                vecs++;
                if (q_o[0] !== ((c == 1) ? 4'b1010 : (c == 2) ? 4'b1011 : 4'b0011)) begin
                    fails++;
                    $display("FAIL set_reset_latency c%0d: got q=%b", c, q_o[0]);
                end
            end
        end
    endtask

    task automatic test_edge();
        int         nconf;
        logic       start_q1;
        int         nrise;
        logic       prev_q2;
        nconf    = 0;
        start_q1 = mq[4][1];
        for (int c = 0; c < 8; c++) begin
            s = (c < 5) ? 4'b0010 : 4'b0000;
            r = s;
            step();
            if (conf_o[4][1]) nconf++;
            for (int m = 0; m < ND; m++) begin
                vecs++;
                if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {mq[m], ~mq[m], mconf[m], merr[m], |merr[m]}) begin
                    fails++;
                    $display("FAIL edge c%0d dut%0d: got %s, want %s", c, m, got_str(m), want_str(m));
                end
            end
        end
        vecs++;
        if (nconf !== 1 || q_o[4][1] !== ~start_q1) begin
            fails++;
            $display("FAIL edge_once: got %0d conflict pulses q1=%b, want 1 pulse q1=%b", nconf, q_o[4][1], ~start_q1);
        end
        // s held high through reset release must act exactly once.
        rst_n = 1'b0;
        s = 4'b0100; r = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nrise   = 0;
        prev_q2 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            r = (c == 2) ? 4'b0100 : 4'b0000;
            step();
            if (q_o[4][2] && !prev_q2) nrise++;
            prev_q2 = q_o[4][2];
            for (int m = 0; m < ND; m++) begin
                vecs++;
                if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {mq[m], ~mq[m], mconf[m], merr[m], |merr[m]}) begin
                    fails++;
                    $display("FAIL edge_release c%0d dut%0d: got %s, want %s", c, m, got_str(m), want_str(m));
                end
            end
        end
        vecs++;
        if (nrise !== 1 || q_o[4][2] !== 1'b0) begin
            fails++;
            $display("FAIL edge_release_once: got %0d set events q2=%b, want 1 event q2=0", nrise, q_o[4][2]);
        end
        s = '0; r = '0;
    endtask

    task automatic test_collision();
        int   nconf [ND];
        logic q0_start [ND];
        logic want_q0;
        for (int m = 0; m < ND; m++) begin
            nconf[m] = 0; q0_start[m] = mq[m][0];
        end
        for (int c = 0; c < 7; c++) begin
            s = (c < 4) ? 4'b0001 : 4'b0000;
            r = s;
            step();
            for (int m = 0; m < ND; m++) begin
                if (conf_o[m][0]) nconf[m]++;
                vecs++;
                if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {mq[m], ~mq[m], mconf[m], merr[m], |merr[m]}) begin
                    fails++;
                    $display("FAIL collision c%0d dut%0d: got %s, want %s", c, m, got_str(m), want_str(m));
                end
            end
        end
        for (int m = 0; m < ND; m++) begin
            case (m)
                0:       want_q0 = 1'b0;
                1:       want_q0 = 1'b1;
                4:       want_q0 = ~q0_start[m];
                default: want_q0 = q0_start[m];
            endcase
            vecs++;
            if (q_o[m][0] !== want_q0 || nconf[m] !== ((m < 4) ? 4 : 1) ||
                err_o[m][0] !== 1'b1 || anyerr_o[m] !== 1'b1) begin
                fails++;
                $display("FAIL collision_mode dut%0d: got q0=%b pulses=%0d err0=%b any=%b, want q0=%b pulses=%0d err0=1 any=1",
                         m, q_o[m][0], nconf[m], err_o[m][0], anyerr_o[m], want_q0, (m < 4) ? 4 : 1);
            end
        end
    endtask

    task automatic test_clr_en();
        for (int c = 0; c < 11; c++) begin
            clr = (c == 3);
            en  = !(c >= 4 && c <= 7);
            if (c < 4)      begin s = 4'b1111; r = 4'b0000; end
            else if (c < 8) begin s = 4'b0101; r = 4'b1010; end
            else            begin s = 4'b0000; r = 4'b0000; end
            step();
            for (int m = 0; m < ND; m++) begin
                vecs++;
                if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {mq[m], ~mq[m], mconf[m], merr[m], |merr[m]}) begin
                    fails++;
                    $display("FAIL clr_en c%0d dut%0d: got %s, want %s", c, m, got_str(m), want_str(m));
                end
                if (c >= 2 && c <= 7) begin
                    vecs++;
                    if (q_o[m] !== ((c == 2) ? 4'b1111 : RV) || (c >= 3 && conf_o[m] !== 4'b0000)) begin
                        fails++;
                        $display("FAIL clr_en_prio c%0d dut%0d: got q=%b conflict=%b", c, m, q_o[m], conf_o[m]);
                    end
                end
            end
        end
        clr = 1'b0; en = 1'b1;
    endtask

    task automatic test_sticky_race();
        for (int c = 0; c < 5; c++) begin
            s       = (c == 0) ? 4'b0100 : 4'b0000;
            r       = s;
            err_clr = (c == 2 || c == 3);
            step();
            for (int m = 0; m < ND; m++) begin
                vecs++;
                if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {mq[m], ~mq[m], mconf[m], merr[m], |merr[m]}) begin
                    fails++;
                    $display("FAIL sticky c%0d dut%0d: got %s, want %s", c, m, got_str(m), want_str(m));
                end
                if ((c == 2 && m < 4) || c == 3) begin
                    vecs++;
                    if (err_o[m] !== ((c == 2) ? 4'b0100 : 4'b0000) || anyerr_o[m] !== (c == 2)) begin
                        fails++;
                        $display("FAIL sticky_race c%0d dut%0d: got err=%b any=%b", c, m, err_o[m], anyerr_o[m]);
                    end
                end
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] st [5] = '{4'b0001, 4'b0110, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] rt [5] = '{4'b0001, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
        for (int c = 0; c < 5; c++) begin
            s = st[c]; r = rt[c];
            step();
            for (int m = 0; m < ND; m++) begin
                vecs++;
                if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {mq[m], ~mq[m], mconf[m], merr[m], |merr[m]}) begin
                    fails++;
                    $display("FAIL async_setup c%0d dut%0d: got %s, want %s", c, m, got_str(m), want_str(m));
                end
            end
        end
        vecs++;
        if (q_o[0] !== 4'b0110 || err_o[0] !== 4'b0001) begin
            fails++;
            $display("FAIL async_precond: got q=%b err=%b, want q=0110 err=0001", q_o[0], err_o[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < ND; m++) begin
            vecs++;
            if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {RV, ~RV, 8'h00, 1'b0}) begin
                fails++;
                $display("FAIL async_reset dut%0d: got %s, want q=%b with all flags clear", m, got_str(m), RV);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            s       = 4'($urandom);
            r       = 4'($urandom);
            en      = ($urandom_range(0, 7) != 0);
            clr     = ($urandom_range(0, 15) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            step();
            for (int m = 0; m < ND; m++) begin
                vecs++;
                if ({q_o[m], qn_o[m], conf_o[m], err_o[m], anyerr_o[m]} !== {mq[m], ~mq[m], mconf[m], merr[m], |merr[m]}) begin
                    fails++;
                    $display("FAIL random c%0d dut%0d: got %s, want %s", c, m, got_str(m), want_str(m));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_reset();
        test_edge();
        test_collision();
        test_clr_en();
        test_sticky_race();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
